// File: rtl/reduce_pipe_if.sv
`default_nettype none
// ============================================================================
// reduce_pipe_if : operand/result handshake bundle for reduce_pipe
// Revision      : 1.0 - initial release
// ============================================================================
interface reduce_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic             out_y;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  // master drives operands and consumes results
  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_y, out_err, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_y, out_err, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/reduce_pipe.sv
`default_nettype none
// ============================================================================
// reduce_pipe : two-stage AND/OR/XOR (and inverted) bit reduction with
//               valid/ready flow control and a single global advance
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  reduce_pipe_if.slave bus
);
  localparam int         NP     = (WIDTH + GROUP - 1) / GROUP;
  localparam int         PADW   = NP * GROUP;
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  // reserved modes 6/7 fall through to AND
  function automatic logic [1:0] base_op(input logic [2:0] mode);
    case (mode)
      3'd1, 3'd4: base_op = OP_OR;
      3'd2, 3'd5: base_op = OP_XOR;
      default:    base_op = OP_AND;
    endcase
  endfunction

  logic            advance;
  logic [1:0]      in_op;
  logic [1:0]      s1_op;
  logic [PADW-1:0] padded;
  logic [NP-1:0]   part;
  logic            combined;
  logic            invert;

  logic            s1_valid_q, s1_valid_d;
  logic [2:0]      s1_mode_q,  s1_mode_d;
  logic [NP-1:0]   s1_part_q,  s1_part_d;
  logic            out_y_q,     out_y_d;
  logic            out_err_q,   out_err_d;
  logic            out_valid_q, out_valid_d;

  assign advance = !out_valid_q || bus.out_ready;
  assign in_op   = base_op(bus.in_mode);
  assign s1_op   = base_op(s1_mode_q);

  // the unused tail of the last group carries the identity of the base op
  always_comb begin
    padded              = {PADW{in_op == OP_AND}};
    padded[WIDTH-1:0]   = bus.in_data;
  end

  for (genvar k = 0; k < NP; k++) begin : g_part
    logic [GROUP-1:0] grp;
    assign grp     = padded[k*GROUP +: GROUP];
    assign part[k] = (in_op == OP_OR)  ? |grp :
                     (in_op == OP_XOR) ? ^grp : &grp;
  end

  always_comb begin
    case (s1_op)
      OP_OR:   combined = |s1_part_q;
      OP_XOR:  combined = ^s1_part_q;
      default: combined = &s1_part_q;
    endcase
    invert = (s1_mode_q == 3'd3) || (s1_mode_q == 3'd4) || (s1_mode_q == 3'd5);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_part_d   = s1_part_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;
    if (advance) begin
      s1_valid_d  = bus.in_valid;
      out_valid_d = s1_valid_q;
      // payload only moves with a real transaction; bubbles leave it alone
      if (bus.in_valid) begin
        s1_mode_d = bus.in_mode;
        s1_part_d = part;
      end
      if (s1_valid_q) begin
        out_y_d   = combined ^ invert;
        out_err_d = s1_mode_q[2] & s1_mode_q[1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 3'd0;
      s1_part_q   <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_part_q   <= s1_part_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_y     = out_y_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_reduce_pipe.sv
`default_nettype none
// ============================================================================
// tb_reduce_pipe : vector table, directed flow-control sequences and random
//                  traffic against a counting-based reference model
// Revision       : 1.0 - initial release
// ============================================================================
module tb_reduce_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reduce_pipe_if #(.WIDTH(8))  bus8  ();
  reduce_pipe_if #(.WIDTH(10)) bus10 ();

  reduce_pipe #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  reduce_pipe #(.WIDTH(10), .GROUP(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  typedef struct {
    logic [9:0] data;
    logic [2:0] mode;
    logic       y;
    logic       err;
    bit         wide;
  } vec_t;

  vec_t       vecs[18];
  logic [1:0] sbq8[$];
  logic [1:0] sbq10[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // result from counting ones over the whole word: {err, y}
  function automatic logic [1:0] ref_model(input logic [63:0] d, input int w, input logic [2:0] m);
    int   ones = $countones(d);
    logic all1 = (ones == w);
    logic any1 = (ones != 0);
    logic par  = ones[0];
    case (m)
      3'd0:    return {1'b0, all1};
      3'd1:    return {1'b0, any1};
      3'd2:    return {1'b0, par};
      3'd3:    return {1'b0, !all1};
      3'd4:    return {1'b0, !any1};
      3'd5:    return {1'b0, !par};
      default: return {1'b1, all1};
    endcase
  endfunction

  task automatic drive(input logic [9:0] d, input logic [2:0] m, input logic v);
    bus8.in_data   = d[7:0];
    bus10.in_data  = d;
    bus8.in_mode   = m;
    bus10.in_mode  = m;
    bus8.in_valid  = v;
    bus10.in_valid = v;
  endtask

  task automatic set_ready(input logic r);
    bus8.out_ready  = r;
    bus10.out_ready = r;
  endtask

  // scoreboards and stall-hold check, sampled mid-cycle
  logic prev_stall = 1'b0;
  logic prev_y, prev_err;
  always @(negedge clk) begin
    if (rst) begin
      sbq8.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus8.out_valid, 1);
        check("hold_y",     bus8.out_y,     prev_y);
        check("hold_err",   bus8.out_err,   prev_err);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        total++;
        if (sbq8.size() == 0) begin
          bad++;
          $display("FAIL sb8_extra: got unexpected result y=%0b expected none", bus8.out_y);
        end else begin
          logic [1:0] e;
          total--;
          e = sbq8.pop_front();
          check("sb8_y",   bus8.out_y,   e[0]);
          check("sb8_err", bus8.out_err, e[1]);
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        sbq8.push_back(ref_model({56'b0, bus8.in_data}, 8, bus8.in_mode));
      prev_stall = bus8.out_valid && !bus8.out_ready;
      prev_y     = bus8.out_y;
      prev_err   = bus8.out_err;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sbq10.delete();
    end else begin
      if (bus10.out_valid && bus10.out_ready) begin
        total++;
        if (sbq10.size() == 0) begin
          bad++;
          $display("FAIL sb10_extra: got unexpected result y=%0b expected none", bus10.out_y);
        end else begin
          logic [1:0] e;
          total--;
          e = sbq10.pop_front();
          check("sb10_y",   bus10.out_y,   e[0]);
          check("sb10_err", bus10.out_err, e[1]);
        end
      end
      if (bus10.in_valid && bus10.in_ready)
        sbq10.push_back(ref_model({54'b0, bus10.in_data}, 10, bus10.in_mode));
    end
  end

  // one isolated transaction; result visible after the second edge counting the accept edge
  task automatic run_vec(input vec_t v);
    drive(v.data, v.mode, 1'b1);
    #1;
    check("vec_in_ready", v.wide ? bus10.in_ready : bus8.in_ready, 1);
    @(posedge clk); #1;
    drive(10'h0, 3'd0, 1'b0);
    check("vec_early_valid", v.wide ? bus10.out_valid : bus8.out_valid, 0);
    @(posedge clk); #1;
    check("vec_valid", v.wide ? bus10.out_valid : bus8.out_valid, 1);
    check("vec_y",     v.wide ? bus10.out_y     : bus8.out_y,     v.y);
    check("vec_err",   v.wide ? bus10.out_err   : bus8.out_err,   v.err);
    @(posedge clk); #1;
    check("vec_no_dup", v.wide ? bus10.out_valid : bus8.out_valid, 0);
  endtask

  task automatic all_modes();
    logic exp_y[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c <= 6; c++) begin
      if (c < 6) drive(10'h00F, 3'(c), 1'b1);
      else       drive(10'h0, 3'd0, 1'b0);
      @(posedge clk); #1;
      if (c >= 1) begin
        check("modes_valid", bus8.out_valid, 1);
        check("modes_y",     bus8.out_y,     exp_y[c-1]);
        check("modes_err",   bus8.out_err,   0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    logic [7:0] bd[4] = '{8'hFF, 8'h0F, 8'h01, 8'h00};
    logic [2:0] bm[4] = '{3'd0, 3'd2, 3'd1, 3'd5};
    int   idx = 0;
    int   got = 0;
    int   stall = 0;
    bit   first = 0;
    logic acc, rdy;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (idx < 4) drive({2'b0, bd[idx]}, bm[idx], 1'b1);
      else         drive(10'h0, 3'd0, 1'b0);
      rdy = (stall == 0);
      set_ready(rdy);
      @(negedge clk);
      if (!rdy) begin
        check("bp_in_ready",  bus8.in_ready,  0);
        check("bp_out_valid", bus8.out_valid, 1);
      end
      acc = bus8.in_valid && bus8.in_ready;
      if (bus8.out_valid && bus8.out_ready) begin
        got++;
        if (!first) begin
          first = 1;
          stall = 3;
        end
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (!rdy) stall--;
    end
    check("bp_count", got, 4);
    drive(10'h0, 3'd0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    vec_t v;
    set_ready(1'b1);
    drive(10'h0FF, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    drive(10'h0, 3'd0, 1'b0);
    check("rm_pre_valid", bus8.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rm_valid", bus8.out_valid, 0);
    check("rm_y",     bus8.out_y,     0);
    check("rm_ready", bus8.in_ready,  1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rm_stale", bus8.out_valid, 0);
    end
    v = '{10'h0FF, 3'd0, 1'b1, 1'b0, 1'b0};
    run_vec(v);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{10'h0FF, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{10'h0FE, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{10'h0FF, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{10'h07F, 3'd6, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{10'h000, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{10'h001, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{10'h003, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{10'h0FF, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{10'h000, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{10'h080, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{10'h0A5, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{10'h3FF, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{10'h200, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{10'h000, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{10'h1FF, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{10'h100, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{10'h300, 3'd5, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{10'h2FF, 3'd7, 1'b0, 1'b1, 1'b1};

    drive(10'h0, 3'd0, 1'b0);
    set_ready(1'b1);
    #3;
    check("rst_valid", bus8.out_valid, 0);
    check("rst_y",     bus8.out_y,     0);
    check("rst_err",   bus8.out_err,   0);
    check("rst_ready", bus8.in_ready,  1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    all_modes();
    backpressure();
    reset_mid();

    for (int c = 0; c < 400; c++) begin
      drive(10'($urandom), 3'($urandom_range(0, 7)), ($urandom % 4) != 0);
      set_ready(($urandom % 3) != 0);
      @(posedge clk); #1;
    end
    drive(10'h0, 3'd0, 1'b0);
    set_ready(1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("drain8",  sbq8.size(),  0);
    check("drain10", sbq10.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
